// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, sizes and small-sigma helpers for the message-schedule path.
// Consumers: sha256_sched_word, sha256_msg_sched.
package sha256_pkg;

  typedef logic [31:0] word_t;

  localparam int SHA_WORDS_IN = 16;
  localparam int SHA_ROUNDS   = 64;

  // small-sigma rotate/shift amounts
  localparam int unsigned S0_ROT_A = 7;
  localparam int unsigned S0_ROT_B = 18;
  localparam int unsigned S0_SHR   = 3;
  localparam int unsigned S1_ROT_A = 17;
  localparam int unsigned S1_ROT_B = 19;
  localparam int unsigned S1_SHR   = 10;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_EMIT = 1'b1
  } sched_state_e;

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic word_t small_sigma0(input word_t x);
    return rotr(x, S0_ROT_A) ^ rotr(x, S0_ROT_B) ^ (x >> S0_SHR);
  endfunction

  function automatic word_t small_sigma1(input word_t x);
    return rotr(x, S1_ROT_A) ^ rotr(x, S1_ROT_B) ^ (x >> S1_SHR);
  endfunction

endpackage

// File: rtl/sha256_sched_word.sv
// Combinational schedule-word generator: new_word = s1(w14) + w9 + s0(w1) + w0 (mod 2^32).
// Window taps are relative to the oldest word w0 of the 16-word window.
module sha256_sched_word
  import sha256_pkg::*;
(
  input  logic [31:0] w0,
  input  logic [31:0] w1,
  input  logic [31:0] w9,
  input  logic [31:0] w14,
  output logic [31:0] new_word
);

  word_t sig0;
  word_t sig1;

  assign sig0     = small_sigma0(w1);
  assign sig1     = small_sigma1(w14);
  assign new_word = sig1 + w9 + sig0 + w0;

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message-schedule expander: loads 16 words, streams W[0..63] over valid/ready.
// Optional macro SCHED_BYTESWAP_EN byte-reverses each accepted input word.
//
// state   | meaning
// --------+----------------------------------------------------------
// ST_LOAD | in_ready=1, shifting M[0..15] into the window
// ST_EMIT | out_valid=1, presenting w[0]; each accept expands one word
module sha256_msg_sched
  import sha256_pkg::*;
#(
  parameter int WORDS_IN  = SHA_WORDS_IN,
  parameter int WORDS_OUT = SHA_ROUNDS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [5:0]  out_idx,
  output logic        done
);

  localparam logic [3:0] LCNT_LAST = 4'(WORDS_IN - 1);
  localparam logic [5:0] ECNT_LAST = 6'(WORDS_OUT - 1);

  sched_state_e state;
  logic [3:0]   lcnt;
  logic [5:0]   ecnt;
  word_t        win [SHA_WORDS_IN];

  word_t        in_word_eff;
  word_t        new_word;
  logic         in_fire;
  logic         out_fire;

`ifdef SCHED_BYTESWAP_EN
  assign in_word_eff = {in_word[7:0], in_word[15:8], in_word[23:16], in_word[31:24]};
`else
  assign in_word_eff = in_word;
`endif

  sha256_sched_word u_sched_word (
    .w0       (win[0]),
    .w1       (win[1]),
    .w9       (win[9]),
    .w14      (win[14]),
    .new_word (new_word)
  );

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // w[0] and the emit counter are already registered, so they drive the outputs directly
  assign out_word = win[0];
  assign out_idx  = ecnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_LOAD;
      lcnt      <= '0;
      ecnt      <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      done      <= 1'b0;
      for (int i = 0; i < SHA_WORDS_IN; i++) begin
        win[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (in_fire) begin
            for (int i = 0; i < SHA_WORDS_IN - 1; i++) begin
              win[i] <= win[i+1];
            end
            win[SHA_WORDS_IN-1] <= in_word_eff;
            if (lcnt == LCNT_LAST) begin
              lcnt      <= '0;
              state     <= ST_EMIT;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
            end else begin
              lcnt <= lcnt + 4'd1;
            end
          end
        end
        ST_EMIT: begin
          if (out_fire) begin
            for (int i = 0; i < SHA_WORDS_IN - 1; i++) begin
              win[i] <= win[i+1];
            end
            win[SHA_WORDS_IN-1] <= new_word;
            // the word expanded on the final accept is never used; the next load overwrites it
            if (ecnt == ECNT_LAST) begin
              ecnt      <= '0;
              state     <= ST_LOAD;
              in_ready  <= 1'b1;
              out_valid <= 1'b0;
              done      <= 1'b1;
            end else begin
              ecnt <= ecnt + 6'd1;
            end
          end
        end
        default: begin
          state     <= ST_LOAD;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/sha256_msg_sched.md
Name: sha256_msg_sched

Overview:
- Message-schedule expander for the SHA-256 mining core.
- It is the consumer of the small-sigma function blocks: it accepts a 512-bit block as 16 serial 32-bit words over a valid/ready handshake.
- It then streams W[0..63] to the compression round logic over a second valid/ready handshake.
- It sits between the header/padding formatter (upstream) and the round engine (downstream).

Parameters:
- WORDS_IN, 16, number of words loaded per block; fixed by SHA-256 and not to be overridden.
- WORDS_OUT, 64, number of schedule words emitted per block.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  expander can accept a word
- in_word  input  32  message word M[i], big-endian word order
- out_valid  output  1  out_word/out_idx valid
- out_ready  input  1  round engine accepts the word
- out_word  output  32  schedule word W[t]
- out_idx  output  6  t, range 0..63
- done  output  1  one-cycle pulse after W[63] is accepted

Behaviour:
- Storage:
  - 16x32 shift window w[0..15]; w[0] is the oldest word.
  - 4-bit load counter lcnt.
  - 6-bit emit counter ecnt.
- States: LOAD, EMIT.
- Reset values (asynchronous, immediate): state=LOAD, lcnt=0, ecnt=0, window=0, in_ready=1, out_valid=0, out_idx=0, out_word=0, done=0.
- LOAD:
  - in_ready=1, out_valid=0.
  - On in_valid&in_ready: shift in_word into w[15] (window shifts toward w[0]), lcnt++.
  - On the accept with lcnt==15: go to EMIT and set lcnt=0.
- EMIT:
  - in_ready=0, out_valid=1.
  - out_word=w[0], out_idx=ecnt.
  - Both are stable while out_ready=0.
  - On out_valid&out_ready: shift the window and load w[15] with new = s1(w[14]) + w[9] + s0(w[1]) + w[0] (mod 2^32). Then ecnt++.
  - Functions:
    - s0(x) = ROTR7 ^ ROTR18 ^ SHR3
    - s1(x) = ROTR17 ^ ROTR19 ^ SHR10
  - On the accept with ecnt==63: done=1 for the next cycle only, state returns to LOAD, ecnt wraps to 0.
- Latency:
  - First out_valid is asserted the cycle after the 16th input accept.
  - With out_ready held high, one word per cycle: 64 cycles per block.
  - Minimum block period is 80 cycles; LOAD and EMIT do not overlap.
- Boundaries:
  - in_valid in EMIT is ignored because in_ready=0.
  - A new block may begin loading in the same cycle done is high.
  - out_ready low in EMIT stalls with no state change.
  - rst mid-load or mid-emit discards the partial block and restores reset values.
- Combinational path is s0, s1, and a 4-input 32-bit adder. No registered sigma stage.

Optional Feature:
- Macro: SCHED_BYTESWAP_EN.
- Defined: every accepted in_word is byte-reversed before it enters the window ({b0,b1,b2,b3} becomes {b3,b2,b1,b0}). This is for little-endian Bitcoin header fields.
- Undefined: words enter unchanged.
- Emit-side behaviour is identical in both cases.

Decomposition:
- Shared package sha256_pkg holds:
  - word_t (32-bit)
  - SHA_WORDS_IN=16, SHA_ROUNDS=64
  - the s0/s1 rotate and shift constants
- One sub-module, sha256_sched_word: combinational new-word generator with inputs w0, w1, w9, w14 and output new.
  - Instantiates the existing small-sigma blocks or equivalent functions.
  - Has its own unit bench.

Test Plan:
- Reset then "abc" block (M0=0x61626380, M1..M14=0, M15=0x00000018), out_ready=1 -> W0=0x61626380, W15=0x00000018, W16=0x61626380, W17=0x000F0000, out_idx 0..63 consecutive, done pulses once, 80-cycle block period.
- Sub-module unit: w1=0x0000FFFF, w0=w9=w14=0 -> new=0xC1FFDE00, which is s0 alone.
- Backpressure: toggle out_ready randomly during "abc" -> identical W sequence to the first scenario, out_word/out_idx unchanged during every stall cycle.
- in_valid held high through EMIT with junk data -> no words accepted, in_ready=0, second block loads correctly after done.
- Assert rst at out_idx=30 -> out_valid=0 and in_ready=1 immediately; a fresh "abc" load reproduces the first scenario's output.
- With SCHED_BYTESWAP_EN, feed M0=0x80636261 and the rest as in the first scenario -> W0=0x61626380 and W16=0x61626380.
